// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin byte-serial RAM/IO arbiter between instruction cache and load/store buffer
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        flush,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFETCH = 2'd1;
    localparam logic [1:0] LOAD   = 2'd2;
    localparam logic [1:0] STORE  = 2'd3;

    logic [1:0]  state;
    logic [2:0]  cnt, len, idx;
    logic [31:0] base, wdata, rbuf, addr, word, ic_hold, lsb_hold;
    logic        pend, last_lsb;
    logic        rd, st, io_block, rd_issue, wr_go, fin, pick_lsb, grant;

    // cnt counts completed bytes; pend marks a read address issued last cycle whose byte is on mem_din now
    always_comb begin
        rd       = state == IFETCH || state == LOAD;
        st       = state == STORE;
        idx      = cnt + {2'b00, pend};
        addr     = base + {29'd0, idx};
        io_block = addr[17:16] == 2'b11 && io_buffer_full;
        rd_issue = rd && idx < len;
        wr_go    = st && cnt < len && !io_block;
        fin      = rst && rdy && (rd ? pend && cnt == len - 3'd1 && !flush : st && cnt == len);
        pick_lsb = lsb_req && (!ic_req || !last_lsb);
        grant    = state == IDLE && rdy && !flush && (ic_req || lsb_req);
        mem_a    = state == IDLE ? 32'd0 : addr;
        mem_wr   = rst && rdy && wr_go;
        mem_dout = st ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'd0;
        ic_done  = fin && state == IFETCH;
        lsb_done = fin && state != IFETCH;
    end

    // The last read byte is taken straight from mem_din so the word is complete in the done cycle
    always_comb begin
        word = rbuf;
        word[{cnt[1:0], 3'b000} +: 8] = mem_din;
        ic_data   = ic_done ? word : ic_hold;
        lsb_rdata = lsb_done && state == LOAD ? word : lsb_hold;
    end

    // Arbitration, byte sequencing, flush abort and rdy stall handling
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            len      <= 3'd0;
            base     <= 32'd0;
            wdata    <= 32'd0;
            rbuf     <= 32'd0;
            pend     <= 1'b0;
            last_lsb <= 1'b0;
        end else if (grant) begin
            state    <= pick_lsb ? (lsb_wr ? STORE : LOAD) : IFETCH;
            len      <= !pick_lsb || lsb_len[1] ? 3'd4 : lsb_len[0] ? 3'd2 : 3'd1;
            base     <= pick_lsb ? lsb_addr : ic_addr;
            wdata    <= lsb_wdata;
            cnt      <= 3'd0;
            rbuf     <= 32'd0;
            pend     <= 1'b0;
            last_lsb <= pick_lsb;
        end else if (rd && flush) begin
            state <= IDLE;
            pend  <= 1'b0;
        end else if (rdy && state != IDLE) begin
            if (fin)
                state <= IDLE;
            if (rd && pend) begin
                rbuf[{cnt[1:0], 3'b000} +: 8] <= mem_din;
                cnt <= cnt + 3'd1;
            end
            if (wr_go)
                cnt <= cnt + 3'd1;
            pend <= rd_issue;
        end else begin
            pend <= 1'b0;
        end
    end

    // Completed words stay visible until the next completion of the same requester
    always_ff @(posedge clk) begin
        if (!rst) begin
            ic_hold  <= 32'd0;
            lsb_hold <= 32'd0;
        end else begin
            if (ic_done)
                ic_hold <= word;
            if (lsb_done && state == LOAD)
                lsb_hold <= word;
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports: clk, rst, rdy, mem_din, mem_dout, mem_a, mem_wr, io_buffer_full, flush, ic_req, ic_addr, ic_done, ic_data, lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata, lsb_done, lsb_rdata.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 rdy  in  1  pause when low.
REQ-005 mem_din  in  8  RAM/IO read byte, valid the cycle after its address.
REQ-006 mem_dout  out  8  write byte.
REQ-007 mem_a  out  32  byte address.
REQ-008 mem_wr  out  1  1 = write.
REQ-009 io_buffer_full  in  1  UART buffer full.
REQ-010 flush  in  1  misprediction flush.
REQ-011 ic_req / ic_addr  in  1 / 32  icache 4-byte line request and word-aligned address.
REQ-012 ic_done / ic_data  out  1 / 32  one-cycle completion pulse and little-endian word.
REQ-013 lsb_req / lsb_wr / lsb_len  in  1 / 1 / 2  LSB request, 1 = store, size (00 byte, 01 half, 11 word; 10 is treated as word).
REQ-014 lsb_addr / lsb_wdata  in  32 / 32  byte address and store data, low bytes first.
REQ-015 lsb_done / lsb_rdata  out  1 / 32  one-cycle completion pulse and load data, zero-extended.

Function
REQ-016 The FSM SHALL have the states IDLE, IFETCH, LOAD, STORE.
REQ-017 Request inputs SHALL be held stable by requesters until their done pulse.
REQ-018 In IDLE with one request pending, the FSM SHALL grant it; with both pending, it SHALL grant the requester not served last (round-robin, 1-bit last_grant; reset value favours LSB).
REQ-019 On grant, the FSM SHALL latch address, length and data; the byte counter SHALL start at 0.
REQ-020 Read (IFETCH/LOAD), N bytes: in cycle k, drive mem_a = base+k and mem_wr=0 for k=0..N-1; capture mem_din into byte k-1 in cycle k; complete in cycle N with the last byte; latency N+1 cycles from the grant cycle.
REQ-021 Write (STORE), N bytes: drive mem_a = base+k, mem_dout = byte k and mem_wr=1 in cycle k; assert lsb_done in the cycle after the last byte.
REQ-022 The done pulse SHALL last exactly 1 cycle, and ic_data/lsb_rdata SHALL be valid in that cycle and held until the next completion.
REQ-023 The FSM SHALL return to IDLE in the done cycle, and a new grant SHALL be possible in the following cycle.
REQ-024 IO write (addr[17:16]==2'b11) with io_buffer_full=1: the byte SHALL NOT be issued (mem_wr=0, counter held) until io_buffer_full=0.
REQ-025 IO read SHALL follow the normal read timing, with no special handling.
REQ-026 Flush SHALL abort IFETCH and LOAD immediately: return to IDLE, no done pulse, no capture.
REQ-027 Flush SHALL NOT abort STORE, since stores are committed; the store completes normally.
REQ-028 Flush in IDLE SHALL suppress the grant in that cycle.
REQ-029 rdy=0: mem_wr SHALL be forced to 0, state/counter/captured bytes frozen, no done pulse.
REQ-030 rdy=0: a read byte in flight SHALL be discarded and its address re-issued after rdy returns high; capture occurs only if the previous cycle had rdy=1 and issued that address.
REQ-031 Address arithmetic SHALL be 32-bit wrap-around, with no alignment checking.
REQ-032 When not in STORE, mem_wr SHALL be 0.

Reset
REQ-033 On rst=0 at the clock edge: state=IDLE, counter=0, mem_a=0, mem_dout=0, mem_wr=0, ic_done=0, lsb_done=0, ic_data=0, lsb_rdata=0, last_grant=icache.
REQ-034 Reset mid-transaction SHALL abandon the transaction without a done pulse and without further writes.

Verification
REQ-035 Icache fetch @0x100, RAM bytes 13,05,00,00 -> mem_a 0x100..0x103 in 4 cycles; ic_done in cycle 5 with ic_data=0x00000513.
REQ-036 LSB store word 0xDEADBEEF @0x2000 -> writes EF,BE,AD,DE to 0x2000..0x2003 with mem_wr=1 for 4 cycles; lsb_done in the next cycle.
REQ-037 ic_req and lsb_req (load byte) both asserted in the same cycle after reset -> LSB served first; icache granted in the cycle after lsb_done.
REQ-038 Store byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write of 0x41; lsb_done follows.
REQ-039 Flush during byte 2 of IFETCH -> no ic_done, IDLE in the next cycle; a pending lsb store is granted immediately.
REQ-040 rdy dropped for 2 cycles mid-LOAD of a half word -> mem_wr=0 throughout; result equals the unpaused result, delayed by 2 or more cycles.
